// File: rtl/roi_crop.sv
// roi_crop: crops a rectangular region of interest out of a raster pixel
// stream. The ROI corners are sampled at every start-of-frame beat and held
// in shadow registers for the rest of the frame. Cropped pixels leave through
// a single-entry output register with valid/ready handshaking.
module roi_crop #(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [2*COORD_W-1:0] xy_0_i,
    input  logic [2*COORD_W-1:0] xy_1_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [PIX_W-1:0]     s_data_i,
    input  logic                 s_sof_i,
    input  logic                 s_eol_i,
    input  logic                 s_eof_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [PIX_W-1:0]     m_data_o,
    output logic                 m_sof_o,
    output logic                 m_eol_o,
    output logic                 frame_done_o,
    output logic                 roi_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic               m_valid_q, m_valid_d;
    logic [PIX_W-1:0]   m_data_q, m_data_d;
    logic               m_sof_q, m_sof_d;
    logic               m_eol_q, m_eol_d;
    logic               frame_done_q, frame_done_d;
    logic               roi_err_q, roi_err_d;

    // Per-beat view: a sof beat sees the freshly presented ROI and sits at (0,0)
    logic               accept;
    logic               new_err;
    state_t             eff_state;
    logic [COORD_W-1:0] cur_x, cur_y, eff_x0, eff_y0, eff_x1, eff_y1;
    logic               in_roi;

    assign s_ready_o    = ~m_valid_q | m_ready_i;
    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign m_sof_o      = m_sof_q;
    assign m_eol_o      = m_eol_q;
    assign frame_done_o = frame_done_q;
    assign roi_err_o    = roi_err_q;

    // Resolve the coordinates, ROI and state that apply to the beat on the bus
    always_comb begin
        accept  = s_valid_i & s_ready_o;
        new_err = (xy_0_i[COORD_W-1:0] > xy_1_i[COORD_W-1:0]) |
                  (xy_0_i[2*COORD_W-1:COORD_W] > xy_1_i[2*COORD_W-1:COORD_W]);
        if (s_sof_i) begin
            cur_x     = '0;
            cur_y     = '0;
            eff_x0    = xy_0_i[COORD_W-1:0];
            eff_y0    = xy_0_i[2*COORD_W-1:COORD_W];
            eff_x1    = xy_1_i[COORD_W-1:0];
            eff_y1    = xy_1_i[2*COORD_W-1:COORD_W];
            eff_state = new_err ? ST_DROP : ST_ACTIVE;
        end else begin
            cur_x     = x_q;
            cur_y     = y_q;
            eff_x0    = x0_q;
            eff_y0    = y0_q;
            eff_x1    = x1_q;
            eff_y1    = y1_q;
            eff_state = state_q;
        end
        in_roi = (cur_x >= eff_x0) && (cur_x <= eff_x1) &&
                 (cur_y >= eff_y0) && (cur_y <= eff_y1);
    end

    // Next-state logic: FSM, raster counters, shadow ROI and output register
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_sof_d      = m_sof_q;
        m_eol_d      = m_eol_q;
        frame_done_d = 1'b0;
        roi_err_d    = roi_err_q;

        // Downstream took the held beat; a reload below may refill it
        if (m_ready_i) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (s_sof_i) begin
                x0_d      = eff_x0;
                y0_d      = eff_y0;
                x1_d      = eff_x1;
                y1_d      = eff_y1;
                roi_err_d = new_err;
            end

            if (eff_state == ST_ACTIVE && in_roi) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_i;
                m_sof_d   = (cur_x == eff_x0) && (cur_y == eff_y0);
                m_eol_d   = (cur_x == eff_x1);
            end

            // Counters only track position inside a frame; IDLE beats are noise
            if (eff_state != ST_IDLE) begin
                if (s_eol_i) begin
                    x_d = '0;
                    y_d = (cur_y == COORD_MAX) ? cur_y : cur_y + 1'b1;
                end else begin
                    x_d = (cur_x == COORD_MAX) ? cur_x : cur_x + 1'b1;
                    y_d = cur_y;
                end
                state_d = eff_state;
                if (s_eof_i) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
        end
    end

    // State and output registers; reset discards any pending output beat
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eol_q      <= 1'b0;
            frame_done_q <= 1'b0;
            roi_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_sof_q      <= m_sof_d;
            m_eol_q      <= m_eol_d;
            frame_done_q <= frame_done_d;
            roi_err_q    <= roi_err_d;
        end
    end

endmodule

// File: tb/tb_roi_crop.sv
// tb_roi_crop: frame-level bench for roi_crop. Each frame's expected cropped
// stream is produced by a raster-scan model of the ROI rule and compared
// against the handshaked output stream.
module tb_roi_crop;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [31:0] xy_0_i, xy_1_i;
    logic        s_valid_i, s_ready_o;
    logic [7:0]  s_data_i;
    logic        s_sof_i, s_eol_i, s_eof_i;
    logic        m_valid_o, m_ready_i;
    logic [7:0]  m_data_o;
    logic        m_sof_o, m_eol_o, frame_done_o, roi_err_o;

    roi_crop #(.PIX_W(8), .COORD_W(16)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .xy_0_i(xy_0_i), .xy_1_i(xy_1_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_eof_i(s_eof_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_sof_o(m_sof_o), .m_eol_o(m_eol_o),
        .frame_done_o(frame_done_o), .roi_err_o(roi_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef logic [9:0] beat_t;   // {data, sof, eol}
    beat_t exp_q[$];
    beat_t obs_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int fd_exp   = 0;
    bit fd_prev  = 1'b0;
    bit rand_rdy = 1'b0;
    bit rand_vld = 1'b0;
    int cyc        = 0;
    int stall_from = -1000;
    int stall_len  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int x, input int y, input int seed);
        return 8'(x * 37 + y * 101 + seed);
    endfunction

    // Downstream ready: forced low inside a stall window, else random or always 1
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (cyc >= stall_from && cyc < stall_from + stall_len) m_ready_i = 1'b0;
            else if (rand_rdy) m_ready_i = ($urandom_range(0, 3) != 0);
            else m_ready_i = 1'b1;
        end
    end

    // Output monitor: collects transfers, counts frame_done pulses
    always @(negedge clk_i) begin
        if (arst_n_i) begin
            chk("s_ready_rule", 32'(s_ready_o), 32'(!m_valid_o || m_ready_i));
            if (m_valid_o && m_ready_i) obs_q.push_back({m_data_o, m_sof_o, m_eol_o});
            if (frame_done_o) begin
                fd_cnt++;
                chk("fd_width", 32'(fd_prev), 32'd0);
            end
        end
        fd_prev = frame_done_o;
    end

    // Reference: raster scan of the first nbeats pixels, keep those in the ROI
    task automatic model_frame(input int w, input int h, input int x0, input int y0,
                               input int x1, input int y1, input int seed, input int nbeats);
        int k;
        k = 0;
        if (x0 > x1 || y0 > y1) return;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (k < nbeats) begin
                    if (x >= x0 && x <= x1 && y >= y0 && y <= y1)
                        exp_q.push_back({pix(x, y, seed), 1'(x == x0 && y == y0), 1'(x == x1)});
                end
                k++;
            end
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit sof, input bit eol, input bit eof,
                             input bit exp_out, input bit exp_fd);
        int t;
        if (rand_vld) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        end
        s_valid_i = 1'b1; s_data_i = d; s_sof_i = sof; s_eol_i = eol; s_eof_i = eof;
        t = 0;
        @(negedge clk_i);
        while (!s_ready_o && t < 300) begin @(negedge clk_i); t++; end
        if (!s_ready_o) chk("beat_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0; s_eof_i = 1'b0;
        if (exp_out) begin
            chk("out_valid_latency", 32'(m_valid_o), 32'd1);
            chk("out_data_latency", 32'(m_data_o), 32'(d));
        end
        if (exp_fd) chk("fd_after_eof", 32'(frame_done_o), 32'd1);
    endtask

    task automatic send_frame(input int w, input int h, input int x0, input int y0,
                              input int x1, input int y1, input int seed, input int nbeats,
                              input int pre, input bit chg_roi);
        int k;
        bit ok, last;
        xy_0_i = {16'(y0), 16'(x0)};
        xy_1_i = {16'(y1), 16'(x1)};
        ok = (x0 <= x1) && (y0 <= y1);
        for (int i = 0; i < pre; i++)
            send_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        model_frame(w, h, x0, y0, x1, y1, seed, nbeats);
        k = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (k < nbeats) begin
                    last = (x == w - 1) && (y == h - 1);
                    send_beat(pix(x, y, seed), k == 0, x == w - 1, last,
                              ok && x >= x0 && x <= x1 && y >= y0 && y <= y1, last);
                    if (k == 0 && chg_roi) begin
                        xy_0_i = $urandom;
                        xy_1_i = $urandom;
                    end
                end
                k++;
            end
        end
        if (nbeats >= w * h) begin
            fd_exp++;
            chk("roi_err", 32'(roi_err_o), 32'(!ok));
            @(posedge clk_i); #1;
            chk("fd_single", 32'(frame_done_o), 32'd0);
        end
    endtask

    task automatic drain(output int n);
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 2000) begin @(negedge clk_i); t++; end
        repeat (6) @(negedge clk_i);
        n = obs_q.size();
        chk("out_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk("out_beat", 32'(obs_q[i]), 32'(exp_q[i]));
        chk("fd_count", 32'(fd_cnt), 32'(fd_exp));
        exp_q.delete();
        obs_q.delete();
        @(posedge clk_i); #1;
    endtask

    typedef struct {
        int w, h, x0, y0, x1, y1;
        int exp_n;
        bit exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, t;
        tbl[0] = '{8, 4, 2, 1, 4, 2, 6, 1'b0};
        tbl[1] = '{8, 4, 5, 0, 3, 3, 0, 1'b1};
        tbl[2] = '{8, 4, 0, 0, 7, 3, 32, 1'b0};
        tbl[3] = '{8, 4, 7, 3, 7, 3, 1, 1'b0};
        tbl[4] = '{8, 4, 6, 2, 20, 10, 4, 1'b0};
        tbl[5] = '{1, 1, 0, 0, 0, 0, 1, 1'b0};

        arst_n_i = 1'b0;
        xy_0_i = '0; xy_1_i = '0;
        s_valid_i = 1'b0; s_data_i = '0; s_sof_i = 1'b0; s_eol_i = 1'b0; s_eof_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_m_data", 32'(m_data_o), 32'd0);
        chk("rst_sof_eol", 32'({m_sof_o, m_eol_o}), 32'd0);
        chk("rst_fd_err", 32'({frame_done_o, roi_err_o}), 32'd0);
        chk("rst_s_ready", 32'(s_ready_o), 32'd1);
        arst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Directed table of ROI shapes, ready held high
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].w, tbl[i].h, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1,
                       i * 11, tbl[i].w * tbl[i].h, 0, 1'b0);
            drain(n);
            chk("tbl_n_out", 32'(n), 32'(tbl[i].exp_n));
            chk("tbl_roi_err", 32'(roi_err_o), 32'(tbl[i].exp_err));
            $display("frame %0d: roi (%0d,%0d)-(%0d,%0d) -> %0d pixels", i,
                     tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, n);
        end

        // Three-cycle downstream stall right after the crop's first pixel
        fork
            send_frame(8, 4, 2, 1, 4, 2, 77, 32, 0, 1'b0);
            begin
                t = 0;
                @(negedge clk_i);
                while (!(m_valid_o && m_sof_o) && t < 500) begin @(negedge clk_i); t++; end
                chk("stall_trigger", 32'(m_valid_o && m_sof_o), 32'd1);
                stall_len  = 3;
                stall_from = cyc + 1;
                repeat (3) begin
                    @(negedge clk_i);
                    chk("stall_s_ready", 32'(s_ready_o), 32'd0);
                    chk("stall_m_valid", 32'(m_valid_o), 32'd1);
                    chk("stall_m_data", 32'(m_data_o), 32'(pix(3, 1, 77)));
                end
            end
        join
        drain(n);
        stall_from = -1000; stall_len = 0;

        // Restart by a second sof mid-frame: no frame_done for the aborted frame
        send_frame(8, 4, 0, 0, 7, 3, 5, 13, 0, 1'b0);
        chk("restart_no_fd", 32'(fd_cnt), 32'(fd_exp));
        send_frame(8, 4, 0, 0, 7, 3, 9, 32, 0, 1'b0);
        drain(n);

        // Reset while an output beat is stalled
        stall_len  = 100000;
        stall_from = cyc + 1;
        send_frame(8, 4, 0, 0, 7, 3, 3, 1, 0, 1'b0);
        repeat (2) @(negedge clk_i);
        chk("pre_rst_stalled", 32'({m_valid_o, s_ready_o}), 32'b10);
        arst_n_i = 1'b0;
        #1;
        chk("rst_drop_valid", 32'(m_valid_o), 32'd0);
        chk("rst_s_ready_1", 32'(s_ready_o), 32'd1);
        stall_from = -1000; stall_len = 0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
        @(posedge clk_i); #1;
        // Pre-sof beats dropped; ROI changes after sof ignored
        send_frame(8, 4, 2, 1, 4, 2, 21, 32, 3, 1'b1);
        drain(n);
        chk("post_rst_n_out", 32'(n), 32'd6);

        // Randomized frames with random valid gaps, ready and ROI changes
        rand_rdy = 1'b1;
        rand_vld = 1'b1;
        for (int f = 0; f < 30; f++) begin
            int w, h, x0, y0, x1, y1;
            w  = $urandom_range(1, 10);
            h  = $urandom_range(1, 6);
            x0 = $urandom_range(0, 11);
            y0 = $urandom_range(0, 7);
            x1 = $urandom_range(0, 11);
            y1 = $urandom_range(0, 7);
            send_frame(w, h, x0, y0, x1, y1, $urandom_range(0, 255), w * h,
                       $urandom_range(0, 2), 1'b1);
            drain(n);
            $display("rand frame %0d: %0dx%0d roi (%0d,%0d)-(%0d,%0d) -> %0d pixels",
                     f, w, h, x0, y0, x1, y1, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
